// File: rtl/ssp_rx_port.sv
// Receive half of the SSP: deserializes TI-synchronous-serial frames into a small
// FIFO that the host drains with PSEL & ~PWRITE reads.
module ssp_rx_port #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              CLEAR,
  input  logic              PSEL,
  input  logic              PWRITE,
  input  logic              SSPCLKIN,
  input  logic              SSPFSSIN,
  input  logic              SSPRXD,
  output logic [DATA_W-1:0] PRDATA,
  output logic              SSPRXINTR,
  output logic              SSPRXOVR
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [PTR_W:0]   FULL     = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  // Only the low DATA_W-1 bits ever reach a pushed word, so the MSB is not kept.
  logic [DATA_W-2:0] shreg;
  logic [DATA_W-1:0] word;
  logic              clk_q;
  logic              fall;
  logic              lsb;
  logic              pop;
  logic              push;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    count_next;

  assign fall = clk_q & ~SSPCLKIN;
  assign word = {shreg, SSPRXD};
  assign lsb  = (state == SHIFT) && fall && (bit_cnt == LAST_BIT);
  assign pop  = PSEL & ~PWRITE & (count != '0);
  // A full FIFO still takes the word when the host frees a slot in the same cycle.
  assign push = lsb & ((count != FULL) | pop);

  always_comb begin
    // NOTE: default assignment first so no path leaves count_next unassigned (no latch).
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge PCLK) begin
    if (push && !CLEAR) mem[wr_ptr] <= word;
  end

  always_ff @(posedge PCLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (CLEAR) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      clk_q     <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      PRDATA    <= '0;
      SSPRXINTR <= 1'b0;
      SSPRXOVR  <= 1'b0;
    end else begin
      clk_q <= SSPCLKIN;
      if (fall) begin
        case (state)
          IDLE: begin
            if (SSPFSSIN) begin
              state   <= SHIFT;
              bit_cnt <= '0;
            end
          end
          SHIFT: begin
            shreg <= word[DATA_W-2:0];
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              // FSS on the LSB period chains straight into the next frame.
              if (!SSPFSSIN) state <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (pop) begin
        PRDATA <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (lsb && !push) SSPRXOVR <= 1'b1;

      count     <= count_next;
      SSPRXINTR <= (count_next == FULL);
    end
  end

endmodule

// File: tb/tb_ssp_rx_port.sv
// Bench for ssp_rx_port: drives serial frames at PCLK/2 and compares the host-visible
// outputs against a queue-based model of the receive FIFO.
module tb_ssp_rx_port;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              PCLK = 1'b0;
  logic              CLEAR = 1'b1;
  logic              PSEL = 1'b0;
  logic              PWRITE = 1'b0;
  logic              SSPCLKIN = 1'b0;
  logic              SSPFSSIN = 1'b0;
  logic              SSPRXD = 1'b0;
  logic [DATA_W-1:0] PRDATA;
  logic              SSPRXINTR;
  logic              SSPRXOVR;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_q[$];
  logic [7:0] model_prdata;
  logic       model_ovr;

  ssp_rx_port #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .PCLK      (PCLK),
    .CLEAR     (CLEAR),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .SSPCLKIN  (SSPCLKIN),
    .SSPFSSIN  (SSPFSSIN),
    .SSPRXD    (SSPRXD),
    .PRDATA    (PRDATA),
    .SSPRXINTR (SSPRXINTR),
    .SSPRXOVR  (SSPRXOVR)
  );

  always #5 PCLK = ~PCLK;

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".prdata"}, 32'(PRDATA), 32'(model_prdata));
    check({tag, ".intr"}, 32'(SSPRXINTR), 32'(model_q.size() == DEPTH));
    check({tag, ".ovr"}, 32'(SSPRXOVR), 32'(model_ovr));
  endtask

  task automatic model_pop();
    if (model_q.size() > 0) model_prdata = model_q.pop_front();
  endtask

  task automatic do_reset();
    CLEAR = 1'b1;
    PSEL = 1'b0;
    SSPCLKIN = 1'b0;
    SSPFSSIN = 1'b0;
    SSPRXD = 1'b0;
    tick();
    CLEAR = 1'b0;
    model_q.delete();
    model_prdata = '0;
    model_ovr = 1'b0;
  endtask

  // One SSPCLKIN period: high cycle then low cycle; the fall is seen in the low cycle.
  task automatic send_period(input logic fss, input logic d, input logic rd);
    SSPCLKIN = 1'b1;
    SSPFSSIN = fss;
    SSPRXD = d;
    PSEL = 1'b0;
    tick();
    SSPCLKIN = 1'b0;
    PSEL = rd;
    PWRITE = 1'b0;
    tick();
    PSEL = 1'b0;
  endtask

  // start: emit the FSS period first; chain: FSS during the LSB; rd_lsb: host read on the LSB fall.
  task automatic send_frame(input logic [7:0] b, input logic start, input logic chain,
                            input logic rd_lsb);
    if (start) send_period(1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--)
      send_period((i == 0) ? chain : 1'b0, b[i], (i == 0) ? rd_lsb : 1'b0);
    if (rd_lsb) model_pop();
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovr = 1'b1;
  endtask

  task automatic host_read(input logic wr);
    PSEL = 1'b1;
    PWRITE = wr;
    tick();
    PSEL = 1'b0;
    PWRITE = 1'b0;
    if (!wr) model_pop();
  endtask

  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'h35; fill[1] = 8'hAE; fill[2] = 8'h26; fill[3] = 8'h39;

    // Reset state
    tick();
    do_reset();
    check_all("reset");

    // Single frame
    send_frame(8'h35, 1'b1, 1'b0, 1'b0);
    check_all("single.pushed");
    host_read(1'b0);
    check_all("single.read");
    check("single.value", 32'(PRDATA), 32'h35);

    // Fill, then overrun with the FIFO full
    for (int i = 0; i < 4; i++) begin
      send_frame(fill[i], 1'b1, 1'b0, 1'b0);
      check_all($sformatf("fill%0d", i));
    end
    check("fill.intr_high", 32'(SSPRXINTR), 32'd1);
    send_frame(8'h9D, 1'b1, 1'b0, 1'b0);
    check_all("overrun");
    check("overrun.flag", 32'(SSPRXOVR), 32'd1);
    host_read(1'b1);
    check_all("write_ignored");
    for (int i = 0; i < 4; i++) begin
      host_read(1'b0);
      check_all($sformatf("drain%0d", i));
    end
    host_read(1'b0);
    check_all("empty_read");
    check("empty_read.value", 32'(PRDATA), 32'h39);

    // Full FIFO with a read on the LSB fall of the next frame
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(fill[i], 1'b1, 1'b0, 1'b0);
    send_frame(8'hB1, 1'b1, 1'b0, 1'b1);
    check_all("simul");
    check("simul.ovr_low", 32'(SSPRXOVR), 32'd0);
    for (int i = 0; i < 4; i++) begin
      host_read(1'b0);
      check_all($sformatf("simul_drain%0d", i));
    end
    check("simul.last", 32'(PRDATA), 32'hB1);

    // Back-to-back frames
    send_frame(8'h74, 1'b1, 1'b1, 1'b0);
    send_frame(8'h8F, 1'b0, 1'b0, 1'b0);
    check_all("b2b");
    host_read(1'b0);
    check_all("b2b.rd0");
    host_read(1'b0);
    check_all("b2b.rd1");

    // Reset in the middle of a frame
    send_period(1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 4; i--) send_period(1'b0, (8'h55 >> i) & 1'b1, 1'b0);
    do_reset();
    check_all("midreset");
    check("midreset.prdata_zero", 32'(PRDATA), 32'd0);
    send_frame(8'h8F, 1'b1, 1'b0, 1'b0);
    host_read(1'b0);
    check_all("midreset.read");
    check("midreset.value", 32'(PRDATA), 32'h8F);

    // Random mix of frames, chained frames, reads and writes
    do_reset();
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0, 1: send_frame(8'($urandom), 1'b1, 1'b0, ($urandom_range(0, 3) == 0));
        2: begin
          send_frame(8'($urandom), 1'b1, 1'b1, 1'b0);
          send_frame(8'($urandom), 1'b0, 1'b0, ($urandom_range(0, 1) == 0));
        end
        3: host_read(1'b0);
        default: host_read(1'b1);
      endcase
      check_all($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
